// File: rtl/layer_ctrl_pkg.sv
// Shared types and helpers for the layer sequencer.
// Holds the FSM state encoding and counter-width functions.
package layer_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Width of a counter that must be able to hold the value n.
    function automatic int idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_act_buffer.sv
// Activation register file: per-entry write enables, comb read.
// Ports: clk, we_i/wdata_i (one data slice per entry), raddr_i, rdata_o.
module act_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic [DEPTH-1:0]   we_i,
    input  logic [DEPTH*W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [W-1:0]       rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Contents survive reset on purpose; state is rebuilt per vector.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (we_i[k]) mem_q[k] <= wdata_i[k*W +: W];
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (raddr_i == AW'(k)) rdata_o = mem_q[k];
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Fully connected layer sequencer: load, broadcast, collect, drain.
// Ports: upstream in_*, neuron_* broadcast/collect, downstream out_*.
module layer_seq_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter int numInputs     = 30,
    parameter int numNeurons    = 10,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [dataWidth-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [dataWidth-1:0]            neuron_in,
    output logic                            neuron_in_valid,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    input  logic [numNeurons-1:0]           neuron_outvalid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            err_timeout
);

    localparam int IW = idx_w(numInputs);
    localparam int OW = idx_w(numNeurons);
    localparam int TW = idx_w(timeoutCycles);
    localparam int N  = numNeurons;
    localparam int DW = dataWidth;

    localparam logic [IW-1:0] LAST_IN  = IW'(numInputs - 1);
    localparam logic [IW-1:0] N_IN     = IW'(numInputs);
    localparam logic [OW-1:0] LAST_OUT = OW'(numNeurons - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(timeoutCycles - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [OW-1:0]   o_idx_q, o_idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [DW-1:0]   nin_q, nin_d;
    logic            nvld_q, nvld_d;
    logic            err_q, err_d;
    logic            init_q;

    logic                 accept;
    logic [numInputs-1:0] ib_we;
    logic [IW-1:0]        ib_raddr;
    logic [DW-1:0]        ib_rdata;
    logic [N-1:0]         cap;
    logic                 all_done;
    logic                 tmo;
    logic [N-1:0]         ob_we;
    logic [N*DW-1:0]      ob_wdata;
    logic [DW-1:0]        ob_rdata;

    assign accept   = in_valid & in_ready;
    assign ib_raddr = (state_q == STREAM) ? rd_idx_q : '0;

    always_comb begin
        ib_we = '0;
        for (int k = 0; k < numInputs; k++) begin
            ib_we[k] = accept && (wr_idx_q == IW'(k));
        end
    end

    act_buffer #(.W(DW), .DEPTH(numInputs), .AW(IW)) u_ibuf (
        .clk     (clk),
        .we_i    (ib_we),
        .wdata_i ({numInputs{in_data}}),
        .raddr_i (ib_raddr),
        .rdata_o (ib_rdata)
    );

    // First pulse per neuron wins; later repeats are masked by done_q.
    assign cap = (state_q == STREAM || state_q == WAIT)
               ? (neuron_outvalid & ~done_q) : '0;
    assign all_done = &(done_q | cap);
    assign tmo = (state_q == WAIT) && (tcnt_q == T_LAST) && !all_done;
    // On timeout, entries that never reported are written with zero.
    assign ob_we = cap | (tmo ? ~(done_q | cap) : '0);

    always_comb begin
        ob_wdata = '0;
        for (int k = 0; k < N; k++) begin
            if (cap[k]) ob_wdata[k*DW +: DW] = neuron_out[k*DW +: DW];
        end
    end

    act_buffer #(.W(DW), .DEPTH(N), .AW(OW)) u_obuf (
        .clk     (clk),
        .we_i    (ob_we),
        .wdata_i (ob_wdata),
        .raddr_i (o_idx_q),
        .rdata_o (ob_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            o_idx_q  <= '0;
            tcnt_q   <= '0;
            done_q   <= '0;
            nin_q    <= '0;
            nvld_q   <= 1'b0;
            err_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            o_idx_q  <= o_idx_d;
            tcnt_q   <= tcnt_d;
            done_q   <= done_d;
            nin_q    <= nin_d;
            nvld_q   <= nvld_d;
            err_q    <= err_d;
            init_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        o_idx_d  = o_idx_q;
        tcnt_d   = tcnt_q;
        done_d   = done_q | cap;
        nin_d    = nin_q;
        nvld_d   = nvld_q;
        err_d    = err_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IN) begin
                        // Word 0 is preloaded so the burst starts next cycle.
                        wr_idx_d = '0;
                        done_d   = '0;
                        state_d  = STREAM;
                        nin_d    = (numInputs == 1) ? in_data : ib_rdata;
                        nvld_d   = 1'b1;
                        rd_idx_d = IW'(1);
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (rd_idx_q == N_IN) begin
                    nvld_d   = 1'b0;
                    nin_d    = '0;
                    rd_idx_d = '0;
                    tcnt_d   = '0;
                    state_d  = WAIT;
                end else begin
                    nin_d    = ib_rdata;
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            WAIT: begin
                if (tcnt_q != T_LAST) tcnt_d = tcnt_q + 1'b1;
                if (all_done) begin
                    state_d = DRAIN;
                    o_idx_d = '0;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                    o_idx_d = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (o_idx_q == LAST_OUT) begin
                        o_idx_d = '0;
                        state_d = LOAD;
                    end else begin
                        o_idx_d = o_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready        = (state_q == LOAD) && init_q;
        out_valid       = (state_q == DRAIN);
        out_data        = out_valid ? ob_rdata : '0;
        busy            = !((state_q == LOAD) && (wr_idx_q == '0));
        neuron_in       = nin_q;
        neuron_in_valid = nvld_q;
        err_timeout     = err_q;
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: 4 inputs, 2 neurons, timeout 8.
// Neurons are modelled by driving neuron_out/outvalid directly.
module tb_layer_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] neuron_in;
    logic        neuron_in_valid;
    logic [31:0] neuron_out;
    logic [1:0]  neuron_outvalid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;

    int vecs = 0;
    int miss = 0;

    layer_seq_ctrl #(
        .numInputs(4), .numNeurons(2),
        .dataWidth(16), .timeoutCycles(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .neuron_in       (neuron_in),
        .neuron_in_valid (neuron_in_valid),
        .neuron_out      (neuron_out),
        .neuron_outvalid (neuron_outvalid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [63:0] v, input bit gap);
        for (int i = 0; i < 4; i++) begin
            int n;
            in_data  = v[i*16 +: 16];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (n == 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            tick();
            if (gap && i < 3) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic stream_chk(input logic [63:0] v);
        chk("in_ready_stream", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("nin_valid", {31'd0, neuron_in_valid}, 32'd1);
            chk("nin_data", {16'd0, neuron_in}, {16'd0, v[i*16 +: 16]});
            tick();
        end
        chk("nin_valid_end", {31'd0, neuron_in_valid}, 32'd0);
        chk("nin_data_end", {16'd0, neuron_in}, 32'd0);
    endtask

    task automatic pulse(input logic [1:0] m, input logic [31:0] d);
        neuron_outvalid = m;
        neuron_out      = d;
        tick();
        neuron_outvalid = '0;
        neuron_out      = '0;
    endtask

    task automatic drain_chk(input logic [31:0] e);
        out_ready = 1'b1;
        chk("out_valid0", {31'd0, out_valid}, 32'd1);
        chk("out_data0", {16'd0, out_data}, {16'd0, e[15:0]});
        tick();
        chk("out_valid1", {31'd0, out_valid}, 32'd1);
        chk("out_data1", {16'd0, out_data}, {16'd0, e[31:16]});
        tick();
        chk("out_valid_end", {31'd0, out_valid}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        in_data         = '0;
        in_valid        = 1'b0;
        neuron_out      = '0;
        neuron_outvalid = '0;
        out_ready       = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_nin_valid", {31'd0, neuron_in_valid}, 32'd0);
        chk("rst_nin", {16'd0, neuron_in}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        rst = 1'b1;
        chk("first_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("in_ready_up", {31'd0, in_ready}, 32'd1);

        // Nominal: results arrive 5 cycles after the burst
        load4({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        stream_chk({16'd4, 16'd3, 16'd2, 16'd1});
        repeat (4) tick();
        chk("busy_wait", {31'd0, busy}, 32'd1);
        chk("no_out_in_wait", {31'd0, out_valid}, 32'd0);
        pulse(2'b11, {16'h0200, 16'h0100});
        drain_chk({16'h0200, 16'h0100});

        // Upstream gaps still give a contiguous burst
        load4({16'h00d4, 16'h00c3, 16'h00b2, 16'h00a1}, 1'b1);
        stream_chk({16'h00d4, 16'h00c3, 16'h00b2, 16'h00a1});
        pulse(2'b11, {16'h0022, 16'h0011});
        drain_chk({16'h0022, 16'h0011});

        // Out-of-order completion with an ignored repeat
        load4({16'd8, 16'd7, 16'd6, 16'd5}, 1'b0);
        stream_chk({16'd8, 16'd7, 16'd6, 16'd5});
        pulse(2'b10, {16'h0AAA, 16'h0000});
        pulse(2'b10, {16'h0FFF, 16'h0000});
        chk("ooo_still_wait", {31'd0, out_valid}, 32'd0);
        pulse(2'b01, {16'h0000, 16'h0555});
        drain_chk({16'h0AAA, 16'h0555});
        chk("ooo_no_err", {31'd0, err_timeout}, 32'd0);

        // Downstream backpressure
        load4({16'd12, 16'd11, 16'd10, 16'd9}, 1'b0);
        stream_chk({16'd12, 16'd11, 16'd10, 16'd9});
        out_ready = 1'b0;
        pulse(2'b11, {16'h0044, 16'h0033});
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", {16'd0, out_data}, 32'h0033);
            tick();
        end
        drain_chk({16'h0044, 16'h0033});

        // Timeout: neuron 1 never answers
        load4({16'd16, 16'd15, 16'd14, 16'd13}, 1'b0);
        stream_chk({16'd16, 16'd15, 16'd14, 16'd13});
        pulse(2'b01, {16'h0000, 16'h0123});
        repeat (6) tick();
        chk("tmo_err_before", {31'd0, err_timeout}, 32'd0);
        chk("tmo_out_before", {31'd0, out_valid}, 32'd0);
        tick();
        chk("tmo_err_set", {31'd0, err_timeout}, 32'd1);
        drain_chk({16'h0000, 16'h0123});

        // Next vector proceeds; error stays sticky
        load4({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        stream_chk({16'd4, 16'd3, 16'd2, 16'd1});
        pulse(2'b11, {16'h0200, 16'h0100});
        drain_chk({16'h0200, 16'h0100});
        chk("err_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset during burst word 2
        load4({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1'b0);
        chk("mid_w0", {16'd0, neuron_in}, 32'h0010);
        tick();
        chk("mid_w1", {16'd0, neuron_in}, 32'h0020);
        tick();
        chk("mid_w2", {16'd0, neuron_in}, 32'h0030);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, neuron_in_valid}, 32'd0);
        chk("mid_rst_nin", {16'd0, neuron_in}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, err_timeout}, 32'd0);
        tick();
        rst = 1'b1;
        chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rel_out_valid", {31'd0, out_valid}, 32'd0);
        load4({16'h0009, 16'h0008, 16'h0007, 16'h0006}, 1'b0);
        stream_chk({16'h0009, 16'h0008, 16'h0007, 16'h0006});
        pulse(2'b11, {16'h0BBB, 16'h0CCC});
        drain_chk({16'h0BBB, 16'h0CCC});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
